// File: rtl/pipe_rc_adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
// Optional saturation is enabled with PIPE_RC_ADDER_SAT_EN.
package pipe_rc_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic v;
    logic c;
  } stage_cv_t;

  function automatic int num_stages(
    input int width,
    input int stage_w
  );
    return width / stage_w;
  endfunction

endpackage

// File: rtl/pipe_rc_adder_stage.sv
// One STAGE_W-bit ripple chunk with its sum, carry and valid
// registers; everything holds while en is low.
module pipe_rc_adder_stage
  import pipe_rc_adder_pkg::*;
#(
  parameter int STAGE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [STAGE_W-1:0] a,
  input  logic [STAGE_W-1:0] b,
  input  stage_cv_t          prev,
  output logic [STAGE_W-1:0] s,
  output stage_cv_t          cv
);

  logic [STAGE_W-1:0] sn;
  logic               c;

  // Bit-serial carry ripple across the chunk
  always_comb begin
    sn = '0;
    c  = prev.c;
    for (int i = 0; i < STAGE_W; i++) begin
      sn[i] = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

  // Capture chunk sum, carry-out and slot valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s  <= '0;
      cv <= '0;
    end else if (en) begin
      s  <= sn;
      cv <= '{v: prev.v, c: c};
    end
  end

endmodule

// File: rtl/pipe_rc_adder.sv
// Pipelined WIDTH-bit add/subtract, one chunk per register stage.
// Define PIPE_RC_ADDER_SAT_EN to clamp overflowed sums.
module pipe_rc_adder
  import pipe_rc_adder_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = num_stages(WIDTH, STAGE_W);
  localparam int SW = STAGE_W;

  logic             adv;
  logic [WIDTH-1:0] beff;
  logic [WIDTH-1:0] raw;
  logic             am;
  logic             bm;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign beff     = (sub == MODE_ADD) ? b : ~b;

  for (genvar k = 0; k < NS; k++) begin : g
    logic [(NS-k)*SW-1:0] ua;
    logic [(NS-k)*SW-1:0] ub;
    logic [(k+1)*SW-1:0]  res;
    logic [SW-1:0]        s;
    stage_cv_t            prev;
    stage_cv_t            cv;

    if (k == 0) begin : head
      assign ua   = a;
      assign ub   = beff;
      assign res  = s;
      assign prev = '{
        v: in_valid,
        c: (sub == MODE_SUB) ? 1'b1 : cin
      };
    end else begin : body
      logic [k*SW-1:0] lo;

      // Skew pending upper chunks, de-skew finished lower sums
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ua <= '0;
          ub <= '0;
          lo <= '0;
        end else if (adv) begin
          ua <= g[k-1].ua[(NS-k+1)*SW-1:SW];
          ub <= g[k-1].ub[(NS-k+1)*SW-1:SW];
          lo <= g[k-1].res;
        end
      end

      assign prev = g[k-1].cv;
      assign res  = {s, lo};
    end

    pipe_rc_adder_stage #(
      .STAGE_W(SW)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .a    (ua[SW-1:0]),
      .b    (ub[SW-1:0]),
      .prev (prev),
      .s    (s),
      .cv   (cv)
    );
  end

  // Keep operand sign bits beside the final chunk for ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am <= 1'b0;
      bm <= 1'b0;
    end else if (adv) begin
      am <= g[NS-1].ua[SW-1];
      bm <= g[NS-1].ub[SW-1];
    end
  end

  assign out_valid = g[NS-1].cv.v;
  assign cout      = g[NS-1].cv.c;
  assign raw       = g[NS-1].res;
  assign ovf       = (am == bm) && (raw[WIDTH-1] != am);

`ifdef PIPE_RC_ADDER_SAT_EN
  assign sum = ovf ? {am, {(WIDTH-1){~am}}} : raw;
`else
  assign sum = raw;
`endif

endmodule
